// File: rtl/vga_plot_sink.sv
// vga_plot_sink
// -------------
// Receiving end of the pixel-plot stream produced by the drawing blocks.
// Plots land in an internal WIDTH x HEIGHT frame buffer (address y*WIDTH+x).
// The buffer can be swept to colour 0 (CLEAR) or read out in raster order
// over a valid/ready stream (SCAN_RD / SCAN_OUT).
//
// Ports
//   clk, rst                 system clock, asynchronous active-high reset
//   vga_x/vga_y/vga_colour   plot coordinate and colour
//   vga_plot                 plot strobe, one write per cycle high
//   clear_req / scan_req     single-cycle operation requests (taken in IDLE only)
//   busy / done              operation in progress / one-cycle completion pulse
//   pix_x/pix_y/pix_colour   scan-out pixel, held while pix_valid && !pix_ready
//   pix_valid/pix_ready      scan-out handshake
//   pix_last                 marks pixel (WIDTH-1, HEIGHT-1)
//   plot_count / oob_count   saturating counts of accepted / dropped plots
module vga_plot_sink #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int CBITS  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       vga_x,
    input  logic [6:0]       vga_y,
    input  logic [CBITS-1:0] vga_colour,
    input  logic             vga_plot,
    input  logic             clear_req,
    input  logic             scan_req,
    output logic             busy,
    output logic             done,
    output logic [7:0]       pix_x,
    output logic [6:0]       pix_y,
    output logic [CBITS-1:0] pix_colour,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             pix_last,
    output logic [14:0]      plot_count,
    output logic [14:0]      oob_count
);

    localparam int DEPTH  = WIDTH * HEIGHT;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [ADDR_W-1:0] W_A       = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [7:0]        X_LIM     = 8'(WIDTH);
    localparam logic [6:0]        Y_LIM     = 7'(HEIGHT);
    localparam logic [7:0]        X_LAST    = 8'(WIDTH - 1);
    localparam logic [6:0]        Y_LAST    = 7'(HEIGHT - 1);
    localparam logic [14:0]       CNT_MAX   = 15'h7FFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_SCAN_RD  = 3'd2,
        ST_SCAN_OUT = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t             r_state;
    logic [CBITS-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_clr_addr;
    logic [7:0]         r_sx;
    logic [6:0]         r_sy;
    logic               r_busy;
    logic               r_done;
    logic               r_pix_valid;
    logic               r_pix_last;
    logic [7:0]         r_pix_x;
    logic [6:0]         r_pix_y;
    logic [CBITS-1:0]   r_pix_colour;
    logic [14:0]        r_plot_count;
    logic [14:0]        r_oob_count;

    logic               w_in_range;
    logic               w_plot_ok;
    logic               w_plot_drop;
    logic [ADDR_W-1:0]  w_plot_addr;
    logic [ADDR_W-1:0]  w_scan_addr;

    // A plot is accepted only in range and outside the clear sweep; anything
    // else strobed on vga_plot is counted as dropped.
    assign w_in_range  = (vga_x < X_LIM) && (vga_y < Y_LIM);
    assign w_plot_ok   = vga_plot && w_in_range && (r_state != ST_CLEAR);
    assign w_plot_drop = vga_plot && !w_plot_ok;
    // Truncation is harmless: the address is only used when in range.
    assign w_plot_addr = ADDR_W'(vga_y) * W_A + ADDR_W'(vga_x);
    assign w_scan_addr = ADDR_W'(r_sy) * W_A + ADDR_W'(r_sx);

    // Frame buffer write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_addr] <= {CBITS{1'b0}};
        end else if (w_plot_ok) begin
            r_mem[w_plot_addr] <= vga_colour;
        end else begin
            r_mem[w_plot_addr] <= r_mem[w_plot_addr];
        end
    end

    // Saturating plot statistics, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_plot_count <= 15'd0;
            r_oob_count  <= 15'd0;
        end else begin
            if (w_plot_ok && (r_plot_count != CNT_MAX)) begin
                r_plot_count <= r_plot_count + 15'd1;
            end else begin
                r_plot_count <= r_plot_count;
            end
            if (w_plot_drop && (r_oob_count != CNT_MAX)) begin
                r_oob_count <= r_oob_count + 15'd1;
            end else begin
                r_oob_count <= r_oob_count;
            end
        end
    end

    // Control FSM with registered status and scan-out outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_pix_last   <= 1'b0;
            r_pix_x      <= 8'd0;
            r_pix_y      <= 7'd0;
            r_pix_colour <= {CBITS{1'b0}};
            r_clr_addr   <= {ADDR_W{1'b0}};
            r_sx         <= 8'd0;
            r_sy         <= 7'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // clear wins when both requests arrive together
                    if (clear_req) begin
                        r_state    <= ST_CLEAR;
                        r_busy     <= 1'b1;
                        r_clr_addr <= {ADDR_W{1'b0}};
                    end else if (scan_req) begin
                        r_state <= ST_SCAN_RD;
                        r_busy  <= 1'b1;
                        r_sx    <= 8'd0;
                        r_sy    <= 7'd0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_addr == LAST_ADDR) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_clr_addr <= r_clr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_SCAN_RD: begin
                    // synchronous read; a same-cycle plot to this address is
                    // not visible here because the write lands on the same edge
                    r_pix_colour <= r_mem[w_scan_addr];
                    r_pix_x      <= r_sx;
                    r_pix_y      <= r_sy;
                    r_pix_last   <= (r_sx == X_LAST) && (r_sy == Y_LAST);
                    r_pix_valid  <= 1'b1;
                    r_state      <= ST_SCAN_OUT;
                end
                ST_SCAN_OUT: begin
                    if (pix_ready) begin
                        r_pix_valid <= 1'b0;
                        r_pix_last  <= 1'b0;
                        if (r_pix_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_SCAN_RD;
                            if (r_sx == X_LAST) begin
                                r_sx <= 8'd0;
                                r_sy <= r_sy + 7'd1;
                            end else begin
                                r_sx <= r_sx + 8'd1;
                            end
                        end
                    end else begin
                        r_state <= ST_SCAN_OUT;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_pix_valid <= 1'b0;
                    r_pix_last  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign pix_valid  = r_pix_valid;
    assign pix_last   = r_pix_last;
    assign pix_x      = r_pix_x;
    assign pix_y      = r_pix_y;
    assign pix_colour = r_pix_colour;
    assign plot_count = r_plot_count;
    assign oob_count  = r_oob_count;

endmodule

// File: tb/tb_vga_plot_sink.sv
// Self-checking bench for vga_plot_sink, run on a reduced 40x30 frame so that
// several full clears and scans fit in a short run. The reference model is a
// flat colour array plus two counters updated from the plot rules.
module tb_vga_plot_sink;
    localparam int W  = 40;
    localparam int H  = 30;
    localparam int N  = W * H;
    localparam int CB = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    vga_x;
    logic [6:0]    vga_y;
    logic [CB-1:0] vga_colour;
    logic          vga_plot, clear_req, scan_req, pix_ready;
    logic          busy, done, pix_valid, pix_last;
    logic [7:0]    pix_x;
    logic [6:0]    pix_y;
    logic [CB-1:0] pix_colour;
    logic [14:0]   plot_count, oob_count;

    int n_cmp = 0;
    int n_err = 0;
    int model [N];
    int m_plot = 0;
    int m_oob  = 0;
    int busy_cnt = 0, done_cnt = 0, valid_cnt = 0;

    always #5 clk = ~clk;

    vga_plot_sink #(.WIDTH(W), .HEIGHT(H), .CBITS(CB)) dut (
        .clk(clk), .rst(rst),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .clear_req(clear_req), .scan_req(scan_req),
        .busy(busy), .done(done),
        .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last),
        .plot_count(plot_count), .oob_count(oob_count)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock, sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
        if (pix_valid === 1'b1) valid_cnt++;
    endtask

    function automatic void model_plot(input int x, input int y, input int c);
        if (x < W && y < H) begin
            model[y * W + x] = c;
            if (m_plot < 32767) m_plot++;
        end else begin
            if (m_oob < 32767) m_oob++;
        end
    endfunction

    task automatic plot(input int x, input int y, input int c);
        vga_x = 8'(x); vga_y = 7'(y); vga_colour = CB'(c); vga_plot = 1'b1;
        tick();
        vga_plot = 1'b0;
        model_plot(x, y, c);
    endtask

    task automatic do_clear(input bit with_scan, input int n_plots);
        busy_cnt = 0; done_cnt = 0; valid_cnt = 0;
        clear_req = 1'b1; scan_req = with_scan;
        tick();
        clear_req = 1'b0; scan_req = 1'b0;
        chk("clr_busy_rise", busy, 1);
        for (int c = 0; c < N + 20 && done !== 1'b1; c++) begin
            if (c == 5) scan_req = 1'b1;
            if (c >= 10 && c < 10 + n_plots) begin
                // in-range plots are still dropped while clearing
                vga_x = 8'($urandom_range(0, W - 1)); vga_y = 7'($urandom_range(0, H - 1));
                vga_colour = CB'($urandom_range(1, 7)); vga_plot = 1'b1;
                if (m_oob < 32767) m_oob++;
            end
            tick();
            scan_req = 1'b0; vga_plot = 1'b0;
        end
        chk("clr_done", done, 1);
        chk("clr_busy_end", busy, 0);
        chk("clr_busy_cycles", busy_cnt, N);
        for (int i = 0; i < N; i++) model[i] = 0;
        tick();
        chk("clr_done_once", done, 0);
        repeat (10) tick();
        chk("clr_done_total", done_cnt, 1);
        chk("clr_no_scan_valid", valid_cnt, 0);
        chk("clr_idle_busy", busy, 0);
    endtask

    task automatic run_scan(input bit rnd, input int abort_at, input int coll_idx);
        int ev, hold, holds, rx, ry;
        logic [31:0] exp_t, obs_t;
        holds = 0;
        busy_cnt = 0; done_cnt = 0;
        pix_ready = 1'b0;
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        chk("scan_busy_rise", busy, 1);
        chk("scan_valid_lat1", pix_valid, 0);
        for (int p = 0; p < N; p++) begin
            // read cycle for pixel p: capture the value before any same-cycle plot
            ev = model[p];
            if (p == coll_idx) begin
                vga_x = 8'(p % W); vga_y = 7'(p / W); vga_colour = CB'((ev + 1) % 8); vga_plot = 1'b1;
                model_plot(p % W, p / W, (ev + 1) % 8);
            end else if (rnd && $urandom_range(0, 15) == 0) begin
                rx = $urandom_range(0, W - 1); ry = $urandom_range(0, H - 1);
                vga_x = 8'(rx); vga_y = 7'(ry); vga_colour = CB'($urandom_range(0, 7)); vga_plot = 1'b1;
                model_plot(rx, ry, int'(vga_colour));
            end
            tick();
            vga_plot = 1'b0;
            exp_t = {13'd0, 8'(p % W), 7'(p / W), CB'(ev), (p == N - 1)};
            obs_t = {13'd0, pix_x, pix_y, pix_colour, pix_last};
            chk("scan_valid", pix_valid, 1);
            chk("scan_pixel", obs_t, exp_t);
            if (p == abort_at) begin
                #3 rst = 1'b1;
                #1;
                chk("abort_valid_async", pix_valid, 0);
                chk("abort_busy_async", busy, 0);
                tick(); tick();
                rst = 1'b0;
                tick(); tick();
                chk("abort_no_done", done_cnt, 0);
                chk("abort_idle", busy, 0);
                m_plot = 0; m_oob = 0;
                return;
            end
            hold = rnd ? ((p == 7) ? 50 : $urandom_range(0, 3)) : 0;
            for (int h = 0; h < hold; h++) begin
                pix_ready = 1'b0;
                tick();
                holds++;
                obs_t = {13'd0, pix_x, pix_y, pix_colour, pix_last};
                chk("hold_valid", pix_valid, 1);
                chk("hold_pixel", obs_t, exp_t);
            end
            pix_ready = 1'b1;
            tick();
            pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            if (p == N - 1) begin
                chk("scan_done", done, 1);
                chk("scan_end_busy", busy, 0);
                chk("scan_end_valid", pix_valid, 0);
            end else begin
                chk("scan_bubble", pix_valid, 0);
            end
        end
        pix_ready = 1'b0;
        chk("scan_busy_cycles", busy_cnt, 2 * N + holds);
        tick();
        chk("scan_done_once", done, 0);
        chk("scan_done_total", done_cnt, 1);
    endtask

    initial begin
        rst = 1'b1; vga_x = 8'd0; vga_y = 7'd0; vga_colour = 3'd0; vga_plot = 1'b0;
        clear_req = 1'b0; scan_req = 1'b0; pix_ready = 1'b0;
        for (int i = 0; i < N; i++) model[i] = 0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", pix_valid, 0);
        chk("rst_last", pix_last, 0);
        chk("rst_xy", {pix_x, pix_y}, 0);
        chk("rst_colour", pix_colour, 0);
        chk("rst_plot_count", plot_count, 0);
        chk("rst_oob_count", oob_count, 0);
        rst = 1'b0;
        tick();

        // clear with plots arriving mid-sweep
        do_clear(1'b0, 3);
        chk("clr_oob_count", oob_count, m_oob);
        chk("clr_plot_count", plot_count, m_plot);

        // three directed plots, then a full scan with ready tied high
        plot(5, 7, 3); plot(W - 1, H - 1, 6); plot(0, 0, 1);
        chk("dir_plot_count", plot_count, 3);
        run_scan(1'b0, -1, -1);

        // out-of-range plots
        plot(W, 0, 5); plot(0, H, 5); plot(255, 127, 5);
        chk("oob_count", oob_count, m_oob);
        chk("oob_plot_unchanged", plot_count, 3);

        // random plots, partly out of range
        for (int i = 0; i < 40; i++)
            plot($urandom_range(0, W + 3), $urandom_range(0, H + 3), $urandom_range(0, 7));
        chk("rnd_plot_count", plot_count, m_plot);
        chk("rnd_oob_count", oob_count, m_oob);

        // random backpressure, plots during scan, forced read/write collision
        run_scan(1'b1, -1, 300);
        chk("scan_plot_count", plot_count, m_plot);

        // clear and scan requested together, plus scan_req mid-clear
        do_clear(1'b1, 4);
        chk("clr2_oob_count", oob_count, m_oob);

        for (int i = 0; i < 20; i++)
            plot($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(1, 7));

        // reset at pixel 1000 of a scan
        run_scan(1'b1, 1000, -1);
        chk("post_rst_plot_count", plot_count, 0);
        chk("post_rst_oob_count", oob_count, 0);

        // fresh scan restarts at (0,0); memory survived the reset
        plot(3, 2, 7); plot(W - 1, 0, 2);
        run_scan(1'b0, -1, -1);
        chk("final_plot_count", plot_count, m_plot);
        chk("final_oob_count", oob_count, m_oob);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
